// File: rtl/shift_seq_pkg.sv
// Shared types and encodings for the shift-register command sequencer.
// Used by shift_seq_ctrl and univ_shift_reg.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } shift_seq_state_t;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_SHL  = 2'b01;
  localparam logic [1:0] CTRL_SHR  = 2'b10;
  localparam logic [1:0] CTRL_LOAD = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic logic [1:0] shift_ctrl(input logic dir);
    return (dir == DIR_RIGHT) ? CTRL_SHR : CTRL_SHL;
  endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// N-bit universal shift register: hold, shift left, shift right, load.
// Shift insert bit comes from d[0] (left) or d[N-1] (right).
module univ_shift_reg
  import shift_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   ctrl,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      unique case (ctrl)
        CTRL_HOLD: q <= q;
        CTRL_SHL:  q <= {q[N-2:0], d[0]};
        CTRL_SHR:  q <= {d[N-1], q[N-1:1]};
        CTRL_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer: load a word, shift it len times, pulse done.
// Optional rotate mode via SHIFT_SEQ_ROTATE_EN adds cmd_rot.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_len,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             cmd_rot,
`endif
  input  logic             ser_in,
  output logic             ser_out,
  output logic [N-1:0]     q,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(N);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  shift_seq_state_t state;
  logic [N-1:0]     data_r;
  logic             dir_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_clamped;
  logic [1:0]       ctrl;
  logic [N-1:0]     d;
  logic             ins;

  assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign cmd_ready   = (state == S_IDLE) && !reset;
  assign busy        = (state != S_IDLE);
  assign ser_out     = (dir_r == DIR_RIGHT) ? q[0] : q[N-1];

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_r;

  // In rotate mode the outgoing bit re-enters at the other end
  assign ins = rot_r ? ser_out : ser_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rot_r <= 1'b0;
    end else if (state == S_IDLE && cmd_valid) begin
      rot_r <= cmd_rot;
    end
  end
`else
  assign ins = ser_in;
`endif

  always_comb begin
    ctrl = CTRL_HOLD;
    d    = data_r;
    unique case (state)
      S_LOAD: ctrl = CTRL_LOAD;
      S_SHIFT: begin
        ctrl = shift_ctrl(dir_r);
        d    = {N{ins}};
      end
      default: ctrl = CTRL_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      data_r <= '0;
      dir_r  <= DIR_LEFT;
      len_r  <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            data_r <= cmd_data;
            dir_r  <= cmd_dir;
            len_r  <= len_clamped;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt <= len_r;
          if (len_r != '0) begin
            state <= S_SHIFT;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_SHIFT: begin
          cnt <= cnt - ONE;
          if (cnt <= ONE) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end

  univ_shift_reg #(
    .N(N)
  ) u_sreg (
    .clk  (clk),
    .reset(reset),
    .ctrl (ctrl),
    .d    (d),
    .q    (q)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl against a transaction-level model.
// Define SHIFT_SEQ_ROTATE_EN to also exercise rotate commands.
module tb_shift_seq_ctrl;

  localparam int N     = 8;
  localparam int CNT_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [N-1:0]     cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_len;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             cmd_rot;
`endif
  logic             ser_in;
  logic             ser_out;
  logic [N-1:0]     q;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;
  int exp_done = 0;
  int accepts = 0;
  int exp_accepts = 0;

  logic [N-1:0] m;

  always #5 clk = ~clk;

  shift_seq_ctrl #(
    .N(N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .cmd_dir  (cmd_dir),
    .cmd_len  (cmd_len),
`ifdef SHIFT_SEQ_ROTATE_EN
    .cmd_rot  (cmd_rot),
`endif
    .ser_in   (ser_in),
    .ser_out  (ser_out),
    .q        (q),
    .busy     (busy),
    .done     (done)
  );

  always @(posedge clk) begin
    if (done) done_seen++;
    if (cmd_valid && cmd_ready) accepts++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scramble_cmd(input bit hold);
    if (!hold) cmd_valid = 1'b0;
    cmd_data = N'($urandom);
    cmd_dir  = 1'($urandom);
    cmd_len  = CNT_W'($urandom);
`ifdef SHIFT_SEQ_ROTATE_EN
    cmd_rot  = 1'($urandom);
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_cmd(input logic [N-1:0] data, input logic dir,
                         input logic [CNT_W-1:0] len, input logic rot,
                         input bit hold, input bit fixed_ser,
                         input logic ser_val);
    int   len_eff;
    logic outb;
    logic ins;
    len_eff = (int'(len) > N) ? N : int'(len);
    cmd_valid = 1'b1;
    cmd_data  = data;
    cmd_dir   = dir;
    cmd_len   = len;
`ifdef SHIFT_SEQ_ROTATE_EN
    cmd_rot   = rot;
`endif
    ser_in    = 1'($urandom);
    chk("ready_idle", int'(cmd_ready), 1);
    chk("busy_idle", int'(busy), 0);
    @(negedge clk);
    exp_accepts++;
    scramble_cmd(hold);
    chk("ready_load", int'(cmd_ready), 0);
    chk("busy_load", int'(busy), 1);
    chk("q_before_load", int'(q), int'(m));
    @(negedge clk);
    m = data;
    chk("q_load", int'(q), int'(m));
    for (int k = 0; k < len_eff; k++) begin
      outb = dir ? m[0] : m[N-1];
      chk("ser_out", int'(ser_out), int'(outb));
      chk("ready_shift", int'(cmd_ready), 0);
      chk("done_shift", int'(done), 0);
      ser_in = fixed_ser ? ser_val : 1'($urandom);
      ins = ser_in;
`ifdef SHIFT_SEQ_ROTATE_EN
      if (rot) ins = outb;
`endif
      @(negedge clk);
      if (dir)
        m = (m >> 1) | (N'(ins) << (N - 1));
      else
        m = (m << 1) | N'(ins);
      chk("q_shift", int'(q), int'(m));
    end
    chk("done_pulse", int'(done), 1);
    chk("ready_done", int'(cmd_ready), 0);
    chk("busy_done", int'(busy), 1);
    exp_done++;
    @(negedge clk);
    chk("done_clear", int'(done), 0);
    chk("busy_end", int'(busy), 0);
    chk("ready_back", int'(cmd_ready), 1);
    chk("q_hold_idle", int'(q), int'(m));
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_dir   = 1'b0;
    cmd_len   = '0;
`ifdef SHIFT_SEQ_ROTATE_EN
    cmd_rot   = 1'b0;
`endif
    ser_in    = 1'b0;
    m         = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_ser_out", int'(ser_out), 0);
    reset = 1'b0;
    @(negedge clk);

    run_cmd(8'hA5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cmd(8'h81, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    run_cmd(8'h81, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    run_cmd(8'hFF, 1'b0, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("q_clamped", int'(q), 0);
    run_cmd(8'h3C, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort a len-5 command during its second shift cycle
    cmd_valid = 1'b1;
    cmd_data  = 8'h5A;
    cmd_dir   = 1'b0;
    cmd_len   = 4'd5;
`ifdef SHIFT_SEQ_ROTATE_EN
    cmd_rot   = 1'b0;
`endif
    @(negedge clk);
    exp_accepts++;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_q", int'(q), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ready", int'(cmd_ready), 0);
    chk("abort_ser_out", int'(ser_out), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", int'(cmd_ready), 1);
    m = '0;
    @(negedge clk);
    chk("post_rst_done", int'(done), 0);
    chk("post_rst_busy", int'(busy), 0);

`ifdef SHIFT_SEQ_ROTATE_EN
    run_cmd(8'h81, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rot_q", int'(q), 8'hC0);
`endif

    for (int i = 0; i < 30; i++) begin
      run_cmd(N'($urandom), 1'($urandom), CNT_W'($urandom),
              1'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk("done_count", done_seen, exp_done);
    chk("accept_count", accepts, exp_accepts);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
